// File: rtl/shift_count_timer.sv
// Delay timer: after a rising start_shifting it loads a 4-bit delay, MSB first,
// from the serial data line, then counts (delay+1) units of CYCLES_PER_UNIT cycles
// and holds done until the user acknowledges.
module shift_count_timer #(
  parameter int unsigned CYCLES_PER_UNIT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_shifting,
  input  logic       data,
  input  logic       ack,
  output logic       counting,
  output logic       done,
  output logic [3:0] count
);

  localparam int unsigned UNIT_W = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(CYCLES_PER_UNIT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COUNT, WAIT_ACK} state_t;

  state_t            state, state_nxt;
  logic              start_d;
  logic [3:0]        delay, delay_nxt;
  logic [1:0]        bits_left, bits_left_nxt;
  logic [UNIT_W-1:0] unit_cnt, unit_nxt;
  logic [3:0]        count_q, count_nxt;
  logic              trigger;

  // Only a rising start_shifting starts a new load, so a level still high after
  // completion cannot retrigger the timer.
  assign trigger = start_shifting & ~start_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      delay     <= 4'd0;
      bits_left <= 2'd0;
      unit_cnt  <= '0;
      count_q   <= 4'd0;
    end else begin
      state     <= state_nxt;
      start_d   <= start_shifting;
      delay     <= delay_nxt;
      bits_left <= bits_left_nxt;
      unit_cnt  <= unit_nxt;
      count_q   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    delay_nxt     = delay;
    bits_left_nxt = bits_left;
    unit_nxt      = unit_cnt;
    count_nxt     = count_q;
    case (state)
      IDLE: begin
        if (trigger) begin
          delay_nxt     = {data, 3'b000};
          bits_left_nxt = 2'd3;
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        delay_nxt[bits_left - 2'd1] = data;
        bits_left_nxt               = bits_left - 2'd1;
        if (bits_left == 2'd1) begin
          count_nxt = delay_nxt;
          unit_nxt  = '0;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (unit_cnt == UNIT_LAST) begin
          unit_nxt = '0;
          // The final unit runs with count already at zero, giving delay+1 units.
          if (count_q == 4'd0) state_nxt = WAIT_ACK;
          else                 count_nxt = count_q - 4'd1;
        end else begin
          unit_nxt = unit_cnt + UNIT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign counting = (state == COUNT);
  assign done     = (state == WAIT_ACK);
  assign count    = count_q;

endmodule

// File: tb/tb_shift_count_timer.sv
// Directed bench for shift_count_timer with CYCLES_PER_UNIT=4.
module tb_shift_count_timer;

  localparam int CPU = 4;

  logic       clk = 1'b0;
  logic       reset, start_shifting, data, ack;
  logic       counting, done;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  shift_count_timer #(.CYCLES_PER_UNIT(CPU)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_shifting(start_shifting),
    .data          (data),
    .ack           (ack),
    .counting      (counting),
    .done          (done),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic shift_in(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) begin
      data = bits[i];
      tick();
    end
  endtask

  // Walk the COUNT phase, checking count each cycle, then its length and done.
  task automatic run_count(input string tag, input int d);
    int n = 0;
    while (counting === 1'b1 && n < 200) begin
      if (n < (d + 1) * CPU) check({tag, "_count"}, int'(count), d - n / CPU);
      tick();
      n++;
    end
    check({tag, "_len"}, n, (d + 1) * CPU);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_cnt0"}, int'(count), 0);
  endtask

  initial begin
    reset = 1'b1; start_shifting = 1'b0; data = 1'b0; ack = 1'b0;
    tick();
    check("rst_counting", int'(counting), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(count), 0);
    reset = 1'b0;
    tick();

    // Basic timing, delay 11
    start_shifting = 1'b1;
    shift_in(4'b1011);
    check("basic_counting", int'(counting), 1);
    run_count("basic", 11);
    tick();
    check("basic_done_hold", int'(done), 1);
    ack = 1'b1;
    tick();
    check("basic_ack_done", int'(done), 0);
    check("basic_ack_counting", int'(counting), 0);
    ack = 1'b0;

    // start_shifting still high: no restart
    for (int i = 0; i < 6; i++) tick();
    check("noretrig_counting", int'(counting), 0);
    check("noretrig_done", int'(done), 0);

    // Drop for a cycle, raise again: zero delay
    start_shifting = 1'b0;
    tick();
    start_shifting = 1'b1;
    shift_in(4'b0000);
    check("zero_counting", int'(counting), 1);
    run_count("zero", 0);

    // Held ack across IDLE and COUNT, delay 1
    ack = 1'b1;
    tick();
    check("ackidle_done", int'(done), 0);
    start_shifting = 1'b0;
    tick();
    start_shifting = 1'b1;
    shift_in(4'b0001);
    check("heldack_counting", int'(counting), 1);
    run_count("heldack", 1);
    tick();
    check("heldack_done_1cyc", int'(done), 0);
    check("heldack_idle", int'(counting), 0);
    ack = 1'b0;

    // Reset during COUNT with count=5 (delay 6)
    start_shifting = 1'b0;
    tick();
    start_shifting = 1'b1;
    shift_in(4'b0110);
    begin
      int n = 0;
      while (count !== 4'd5 && n < 50) begin
        tick();
        n++;
      end
    end
    check("midrst_pre_count", int'(count), 5);
    check("midrst_pre_counting", int'(counting), 1);
    reset = 1'b1;
    tick();
    check("midrst_counting", int'(counting), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_done", int'(done), 0);

    // start_shifting high in first cycle after reset is a trigger; max delay
    reset = 1'b0;
    shift_in(4'b1111);
    check("max_counting", int'(counting), 1);
    run_count("max", 15);
    ack = 1'b1;
    tick();
    check("max_ack_done", int'(done), 0);
    ack = 1'b0;
    tick();
    check("max_idle_counting", int'(counting), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_count_timer.md
SHIFT_COUNT_TIMER -- requirements
Module: shift_count_timer

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_UNIT, default 1000, giving the clock cycles per delay unit; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have port start_shifting, input, 1, a level from the upstream 1101 pattern detector that stays high until that detector is reset.
REQ-005 The block SHALL have port data, input, 1, the serial stream carrying the 4-bit delay MSB-first.
REQ-006 The block SHALL have port ack, input, 1, the user acknowledge of timer completion.
REQ-007 The block SHALL have port counting, output, 1, high while the timer is counting.
REQ-008 The block SHALL have port done, output, 1, high while awaiting ack.
REQ-009 The block SHALL have port count, output, 4, the remaining delay units during counting.

Function
REQ-010 The block SHALL implement four states: IDLE, SHIFT, COUNT and WAIT_ACK.
REQ-011 The block SHALL keep a register start_d holding start_shifting from the previous cycle; a trigger is start_shifting=1 with start_d=0.
REQ-012 In IDLE, a trigger at a clock edge SHALL capture data into delay[3] and move to SHIFT with 3 bits remaining.
REQ-013 In SHIFT, each cycle SHALL shift data into the next lower delay bit (delay[2], then delay[1], then delay[0]).
REQ-014 The edge capturing delay[0] SHALL enter COUNT, with count loaded with the full delay and the unit counter cleared.
REQ-015 The bit sampled at a trigger SHALL be the first data bit after the 1101 pattern, and delay SHALL be the 4 consecutive bits starting there.
REQ-016 In COUNT, the unit counter SHALL increment every cycle and wrap from CYCLES_PER_UNIT-1 to 0.
REQ-017 On each wrap while count>0, count SHALL decrement by 1.
REQ-018 On a wrap with count=0, the block SHALL enter WAIT_ACK.
REQ-019 COUNT SHALL last exactly (delay+1)*CYCLES_PER_UNIT cycles; delay=0 gives CYCLES_PER_UNIT cycles.
REQ-020 Outputs SHALL be: counting=1 only in COUNT, done=1 only in WAIT_ACK, count=0 outside COUNT, all driven from registered state.
REQ-021 In WAIT_ACK, ack=1 at a clock edge SHALL return the block to IDLE; done SHALL fall in the following cycle.
REQ-022 ack SHALL be ignored in all states other than WAIT_ACK.
REQ-023 Triggers outside IDLE SHALL be ignored, while start_d SHALL still track start_shifting every cycle.
REQ-024 After returning to IDLE with start_shifting still high, the block SHALL NOT restart until start_shifting goes low and then high again.
REQ-025 The unit counter SHALL be sized to ceil(log2(CYCLES_PER_UNIT)) bits and SHALL never exceed CYCLES_PER_UNIT-1.

Reset
REQ-026 reset=1 at a clock edge SHALL force state=IDLE, start_d=0, delay=0, unit counter=0, count=0, counting=0 and done=0, overriding all other inputs.
REQ-027 Reset during SHIFT, COUNT or WAIT_ACK SHALL abort the operation with no residual state.
REQ-028 If start_shifting is high in the first cycle after reset, that cycle SHALL be a trigger.

Verification (CYCLES_PER_UNIT=4)
REQ-029 Basic timing: reset, then start_shifting rises with data=1,0,1,1 on the next 4 edges -> counting=1 for 48 cycles, count steps 11..0 every 4 cycles, then done=1; ack=1 for 1 cycle -> done=0 and the block is in IDLE.
REQ-030 Zero delay: delay bits 0,0,0,0 -> counting high for 4 cycles with count=0 throughout, then done=1.
REQ-031 Held ack: ack held high from before COUNT -> no early exit; done is high for exactly 1 cycle.
REQ-032 No retrigger: start_shifting held high after ack -> the block stays in IDLE; dropping it for 1 cycle and raising it again starts a new SHIFT.
REQ-033 Reset mid-operation: reset asserted during COUNT with count=5 -> the next cycle shows counting=0, count=0 and done=0, and the block is in IDLE.
REQ-034 Max delay: delay bits 1,1,1,1 -> counting high for 64 cycles.
